// File: rtl/data_sync_mc.sv
// Multi-channel data synchroniser for the destination clock domain.
//
// Each channel passes its asynchronous qualifier (bus_enable_i[c]) through a
// NUM_STAGES flop chain and detects an event on the synchronised copy. Level mode
// (TOGGLE_MODE=0) fires on a rising edge; toggle mode (TOGGLE_MODE=1) fires on
// either edge. On an event the channel's slice of unsync_bus_i is captured. The
// source holds that slice stable while the event is in flight, so the capture is
// a multi-cycle-path load. The captured word is then held under a valid/ready
// handshake. A sticky overrun flag records a word overwritten before it was
// consumed. An ack toggle flips once per consumed word so the source domain can
// synchronise the return path.
//
// Ports:
//   clk_i           destination-domain clock
//   rst_i           synchronous, active-high reset
//   unsync_bus_i    source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable_i    asynchronous per-channel qualifier
//   sync_ready_i    consumer accepts channel c while sync_valid_o[c] is high
//   overrun_clr_i   clears overrun_o[c]; a set in the same cycle wins
//   sync_bus_o      captured data, registered, held between events
//   enable_pulse_o  one-cycle pulse coincident with the sync_bus_o update
//   sync_valid_o    captured data pending consumption
//   overrun_o       sticky: an event arrived while the previous word was unconsumed
//   ack_toggle_o    flips once per consumed word

module data_sync_mc #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus_i,
  input  logic [NUM_CH-1:0]           bus_enable_i,
  input  logic [NUM_CH-1:0]           sync_ready_i,
  input  logic [NUM_CH-1:0]           overrun_clr_i,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus_o,
  output logic [NUM_CH-1:0]           enable_pulse_o,
  output logic [NUM_CH-1:0]           sync_valid_o,
  output logic [NUM_CH-1:0]           overrun_o,
  output logic [NUM_CH-1:0]           ack_toggle_o
);

  // Channels are fully independent: one copy of the logic per channel.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    // Synchroniser chain: bit 0 samples the asynchronous input.
    logic [NUM_STAGES-1:0] chain_q, chain_d;
    // Synchronised qualifier delayed by one cycle, used for edge detection.
    logic                  prev_q, prev_d;
    logic                  sync_en;
    logic                  evt;

    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  pulse_q, pulse_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;
    logic                  ack_q, ack_d;

    logic                  ready;
    logic                  consume;
    logic                  ovr_set;

    assign sync_en = chain_q[NUM_STAGES-1];
    assign ready   = sync_ready_i[c];

    if (TOGGLE_MODE != 0) begin : g_toggle
      // Toggle source: every transition of the synchronised qualifier is an event.
      assign evt = sync_en ^ prev_q;
    end else begin : g_level
      // Level/pulse source: only the rising edge counts, so a held-high
      // qualifier fires once and cannot re-trigger until it drops.
      assign evt = sync_en & ~prev_q;
    end

    // A word is consumed whenever it is valid and the consumer is ready. This
    // includes the cycle in which a new event reloads the register.
    assign consume = valid_q & ready;

    // Overwriting an unconsumed word that the consumer is not taking this cycle.
    assign ovr_set = evt & valid_q & ~ready;

    always_comb begin
      chain_d = {chain_q[NUM_STAGES-2:0], bus_enable_i[c]};
      prev_d  = sync_en;

      // Capture point of the multi-cycle path: the source slice has been
      // stable since before the qualifier entered the chain.
      bus_d   = evt ? unsync_bus_i[c*BUS_WIDTH +: BUS_WIDTH] : bus_q;
      pulse_d = evt;

      // A new event always leaves a word pending. Otherwise a consumed word
      // drops valid.
      valid_d = evt | (valid_q & ~ready);

      ack_d   = ack_q ^ consume;

      // A set in the same cycle as a clear wins.
      ovr_d   = ovr_set | (ovr_q & ~overrun_clr_i[c]);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        chain_q <= '0;
        prev_q  <= 1'b0;
        bus_q   <= '0;
        pulse_q <= 1'b0;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        chain_q <= chain_d;
        prev_q  <= prev_d;
        bus_q   <= bus_d;
        pulse_q <= pulse_d;
        valid_q <= valid_d;
        ovr_q   <= ovr_d;
        ack_q   <= ack_d;
      end
    end

    assign sync_bus_o[c*BUS_WIDTH +: BUS_WIDTH] = bus_q;
    assign enable_pulse_o[c]                    = pulse_q;
    assign sync_valid_o[c]                      = valid_q;
    assign overrun_o[c]                         = ovr_q;
    assign ack_toggle_o[c]                      = ack_q;

  end : g_ch

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc. Four instances share one stimulus stream:
//   d0 NUM_STAGES=2 level, d1 NUM_STAGES=3 level, d2 NUM_STAGES=4 level,
//   d3 NUM_STAGES=2 toggle.
// A timeline model logs the qualifier seen at every clock edge. An event at edge n
// is derived from the values logged at edges n-NUM_STAGES and n-NUM_STAGES-1.
// Values logged at or before the latest reset edge count as 0.
module tb_data_sync_mc;
  localparam int BW   = 8;
  localparam int NC   = 4;
  localparam int ND   = 4;
  localparam int MAXE = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus = '0;
  logic [3:0]  en  = '0;
  logic [3:0]  rdy = '0;
  logic [3:0]  clr = '0;

  logic [31:0] sb [ND];
  logic [3:0]  ep [ND];
  logic [3:0]  sv [ND];
  logic [3:0]  ov [ND];
  logic [3:0]  ak [ND];

  data_sync_mc #(.BUS_WIDTH(BW), .NUM_STAGES(2), .NUM_CH(NC), .TOGGLE_MODE(0)) u_d0 (
    .clk_i(clk), .rst_i(rst), .unsync_bus_i(bus), .bus_enable_i(en), .sync_ready_i(rdy),
    .overrun_clr_i(clr), .sync_bus_o(sb[0]), .enable_pulse_o(ep[0]), .sync_valid_o(sv[0]),
    .overrun_o(ov[0]), .ack_toggle_o(ak[0]));
  data_sync_mc #(.BUS_WIDTH(BW), .NUM_STAGES(3), .NUM_CH(NC), .TOGGLE_MODE(0)) u_d1 (
    .clk_i(clk), .rst_i(rst), .unsync_bus_i(bus), .bus_enable_i(en), .sync_ready_i(rdy),
    .overrun_clr_i(clr), .sync_bus_o(sb[1]), .enable_pulse_o(ep[1]), .sync_valid_o(sv[1]),
    .overrun_o(ov[1]), .ack_toggle_o(ak[1]));
  data_sync_mc #(.BUS_WIDTH(BW), .NUM_STAGES(4), .NUM_CH(NC), .TOGGLE_MODE(0)) u_d2 (
    .clk_i(clk), .rst_i(rst), .unsync_bus_i(bus), .bus_enable_i(en), .sync_ready_i(rdy),
    .overrun_clr_i(clr), .sync_bus_o(sb[2]), .enable_pulse_o(ep[2]), .sync_valid_o(sv[2]),
    .overrun_o(ov[2]), .ack_toggle_o(ak[2]));
  data_sync_mc #(.BUS_WIDTH(BW), .NUM_STAGES(2), .NUM_CH(NC), .TOGGLE_MODE(1)) u_d3 (
    .clk_i(clk), .rst_i(rst), .unsync_bus_i(bus), .bus_enable_i(en), .sync_ready_i(rdy),
    .overrun_clr_i(clr), .sync_bus_o(sb[3]), .enable_pulse_o(ep[3]), .sync_valid_o(sv[3]),
    .overrun_o(ov[3]), .ack_toggle_o(ak[3]));

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int edge_n   = 0;
  int last_rst = 0;

  logic [3:0]  en_log [MAXE];
  int          ns_of  [ND] = '{2, 3, 4, 2};
  bit          tog_of [ND] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic [31:0] m_bus   [ND];
  logic [3:0]  m_pulse [ND];
  logic [3:0]  m_valid [ND];
  logic [3:0]  m_ovr   [ND];
  logic [3:0]  m_ack   [ND];

  function automatic logic en_at(int m, int c);
    if (m < 1 || m <= last_rst) return 1'b0;
    return en_log[m][c];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock edge: update the model from the inputs present at the edge, then
  // compare every output of every instance 1 time unit later.
  task automatic tick();
    logic a, b, ev;
    @(posedge clk);
    if (edge_n >= MAXE - 1) begin
      $display("FAIL edge_budget observed=%0d expected<%0d", edge_n, MAXE - 1);
      $fatal(1, "edge budget exhausted");
    end
    edge_n++;
    en_log[edge_n] = en;
    if (rst) begin
      last_rst = edge_n;
      for (int d = 0; d < ND; d++) begin
        m_bus[d] = '0; m_pulse[d] = '0; m_valid[d] = '0; m_ovr[d] = '0; m_ack[d] = '0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < NC; c++) begin
          a  = en_at(edge_n - ns_of[d], c);
          b  = en_at(edge_n - ns_of[d] - 1, c);
          ev = tog_of[d] ? (a ^ b) : (a & ~b);
          if (m_valid[d][c] && rdy[c]) m_ack[d][c] = ~m_ack[d][c];
          m_ovr[d][c] = (ev && m_valid[d][c] && !rdy[c]) || (m_ovr[d][c] && !clr[c]);
          if (ev) begin
            m_valid[d][c] = 1'b1;
            m_bus[d][c*BW +: BW] = bus[c*BW +: BW];
          end else if (rdy[c]) begin
            m_valid[d][c] = 1'b0;
          end
          m_pulse[d][c] = ev;
        end
      end
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d.sync_bus@%0d", d, edge_n), sb[d], m_bus[d]);
      check($sformatf("d%0d.enable_pulse@%0d", d, edge_n), {28'b0, ep[d]}, {28'b0, m_pulse[d]});
      check($sformatf("d%0d.sync_valid@%0d", d, edge_n), {28'b0, sv[d]}, {28'b0, m_valid[d]});
      check($sformatf("d%0d.overrun@%0d", d, edge_n), {28'b0, ov[d]}, {28'b0, m_ovr[d]});
      check($sformatf("d%0d.ack_toggle@%0d", d, edge_n), {28'b0, ak[d]}, {28'b0, m_ack[d]});
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      m_bus[d] = '0; m_pulse[d] = '0; m_valid[d] = '0; m_ovr[d] = '0; m_ack[d] = '0;
    end

    // Reset held for two edges: everything reads 0.
    rst = 1'b1;
    ticks(2);
    check("rst.sync_bus", sb[0], 32'h0);
    check("rst.flags", {16'b0, ep[0], sv[0], ov[0], ak[0]}, 32'h0);
    rst = 1'b0;

    // Level capture on ch1 and latency for 2, 3 and 4 stages.
    bus[15:8] = 8'hA5;
    en[1]     = 1'b1;
    ticks(2);
    check("lat2.early_pulse", ep[0], 4'b0000);
    tick();
    check("lat2.pulse", ep[0], 4'b0010);
    check("lat2.data", sb[0][15:8], 8'hA5);
    check("lat2.valid", sv[0][1], 1'b1);
    check("lat2.other_data", {sb[0][31:16], sb[0][7:0]}, 24'h0);
    check("lat3.early_pulse", ep[1][1], 1'b0);
    tick();
    check("lat2.pulse_width", ep[0][1], 1'b0);
    check("lat3.pulse", ep[1][1], 1'b1);
    check("lat4.early_pulse", ep[2][1], 1'b0);
    tick();
    check("lat3.pulse_width", ep[1][1], 1'b0);
    check("lat4.pulse", ep[2][1], 1'b1);
    tick();
    check("lat4.pulse_width", ep[2][1], 1'b0);
    ticks(6);
    check("lvl.no_retrigger", ep[0][1], 1'b0);

    // Handshake on ch0.
    bus[7:0] = 8'h5A;
    en[0]    = 1'b1;
    ticks(6);
    check("hs.valid", sv[0][0], 1'b1);
    check("hs.ack0", ak[0][0], 1'b0);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    check("hs.consumed", sv[0][0], 1'b0);
    check("hs.ack1", ak[0][0], 1'b1);
    en[0] = 1'b0;
    ticks(6);
    en[0] = 1'b1;
    ticks(6);
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    check("hs.ack2", ak[0][0], 1'b0);

    // Overrun on ch2.
    bus[23:16] = 8'h11;
    en[2]      = 1'b1;
    ticks(6);
    en[2] = 1'b0;
    ticks(6);
    bus[23:16] = 8'h22;
    en[2]      = 1'b1;
    ticks(6);
    check("ovr.data", sb[0][23:16], 8'h22);
    check("ovr.set", ov[0][2], 1'b1);
    check("ovr.valid", sv[0][2], 1'b1);
    en[2] = 1'b0;
    ticks(4);
    bus[23:16] = 8'h33;
    en[2]      = 1'b1;
    ticks(2);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("ovr.set_beats_clr", ov[0][2], 1'b1);
    check("ovr.data3", sb[0][23:16], 8'h33);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("ovr.cleared", ov[0][2], 1'b0);

    // Toggle mode on ch3 (d3), with event and ready in the same cycle.
    bus[31:24] = 8'h3C;
    en[3]      = 1'b1;
    ticks(3);
    check("tog.pulse1", ep[3][3], 1'b1);
    check("tog.data1", sb[3][31:24], 8'h3C);
    ticks(3);
    bus[31:24] = 8'hC3;
    en[3]      = 1'b0;
    ticks(2);
    rdy[3] = 1'b1;
    tick();
    rdy[3] = 1'b0;
    check("tog.pulse2", ep[3][3], 1'b1);
    check("tog.data2", sb[3][31:24], 8'hC3);
    check("tog.valid_kept", sv[3][3], 1'b1);
    check("tog.ack_flip", ak[3][3], 1'b1);
    check("tog.no_overrun", ov[3][3], 1'b0);
    check("lvl.fall_no_event", ep[0][3], 1'b0);

    // Reset mid-flight with the qualifier held high.
    en = '0;
    ticks(8);
    en[1] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid.in_reset", ep[0], 4'b0000);
    tick();
    check("rstmid.edge1", ep[0][1], 1'b0);
    tick();
    check("rstmid.edge2", ep[0][1], 1'b0);
    tick();
    check("rstmid.level_pulse", ep[0][1], 1'b1);
    check("rstmid.toggle_pulse", ep[3][1], 1'b1);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      en  = en ^ ($urandom & $urandom & $urandom);
      bus = $urandom;
      rdy = $urandom;
      clr = $urandom & $urandom & $urandom;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_sync_mc.md
Name: data_sync_mc

Overview:
- Multi-channel, parametrised successor to the single-bus data synchroniser.
- Sits in the destination clock domain. Each channel carries its qualifier (bus_enable) through a NUM_STAGES flop chain, detects the event, and captures that channel's bus as a multi-cycle-path load.
- Adds over the single-channel block: selectable level/toggle qualifier mode, per-channel valid/ready hold, sticky overrun flag, and an ack toggle for the return path.

Parameters:
- BUS_WIDTH, 8, data bits per channel (>=1).
- NUM_STAGES, 2, synchroniser depth on bus_enable (>=2).
- NUM_CH, 4, number of independent channels (>=1).
- TOGGLE_MODE, 0, 0 = event on rising edge of bus_enable (level/pulse source); 1 = event on any edge (toggle source).

Ports:
- CLK  input  1  destination-domain clock.
- RST  input  1  synchronous, active-high reset.
- unsync_bus  input  NUM_CH*BUS_WIDTH  source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH]; held stable by source while event in flight.
- bus_enable  input  NUM_CH  asynchronous per-channel qualifier.
- sync_ready  input  NUM_CH  consumer accepts sync_bus of channel c while sync_valid[c]=1.
- overrun_clr  input  NUM_CH  clears overrun[c].
- sync_bus  output  NUM_CH*BUS_WIDTH  captured data, registered.
- enable_pulse  output  NUM_CH  one-cycle pulse, coincident with the sync_bus update.
- sync_valid  output  NUM_CH  captured data pending consumption.
- overrun  output  NUM_CH  sticky: an event arrived while previous data was unconsumed.
- ack_toggle  output  NUM_CH  flips once per consumed word; for return-path sync.

Behaviour:
- Reset (RST=1 at a CLK edge): all sync chains, edge-detect flops, sync_bus, enable_pulse, sync_valid, overrun and ack_toggle clear to 0. Synchronous only, so no effect between edges.
- Channels are fully independent; no cross-channel interaction.
- Chain: stage0 samples bus_enable[c]; stage i samples stage i-1; sync_en = stage NUM_STAGES-1; prev_en = sync_en delayed one cycle.
- Event detection:
  - TOGGLE_MODE=0: event = sync_en & ~prev_en.
  - TOGGLE_MODE=1: event = sync_en ^ prev_en.
- Latency:
  - bus_enable change first sampled at edge k gives sync_en change after edge k+NUM_STAGES-1.
  - At edge k+NUM_STAGES: sync_bus[c] <= unsync_bus[c], enable_pulse[c]=1 for exactly one cycle.
  - NUM_STAGES=2 gives 3 edges.
- sync_bus holds its value between events; it is never cleared except by RST.
- Valid/ready at each edge:
  - event: sync_valid <= 1.
  - else if sync_valid & sync_ready: sync_valid <= 0, ack_toggle flips.
  - Event and ready together with sync_valid=1: old word counts as consumed (ack flips), new word loaded, sync_valid stays 1, no overrun.
- Overrun:
  - Set when event occurs with sync_valid=1 and sync_ready=0. New data overwrites old, sync_valid stays 1.
  - Cleared by overrun_clr. Set has priority over clear in the same cycle.
- Level mode: a bus_enable held high produces a single event, with no re-trigger until it drops for at least 1 synced cycle.
- Toggle mode: each source toggle yields exactly one event. Source must not toggle again within NUM_STAGES+1 destination cycles.
- Reset mid-operation:
  - An in-flight event is discarded.
  - If bus_enable[c] is 1 when RST deasserts, the chain refills from 0 and produces one event NUM_STAGES+1 edges later, in both modes.
- sync_ready while sync_valid=0 is ignored: no ack flip.

Test Plan:
- Reset and level capture, NUM_CH=4, BUS_WIDTH=8, NUM_STAGES=2. Hold RST 2 cycles, expect all outputs 0. Release, set ch1 bus=0xA5, bus_enable[1]=1 before edge 1. Expect sync_bus[1]=0xA5 and enable_pulse[1]=1 only after edge 3, and sync_valid[1]=1. Other channels unchanged.
- Latency sweep NUM_STAGES=3 and 4. Expect pulse after edge 4 and 5 respectively, each exactly 1 cycle wide; bus_enable held high gives no second pulse.
- Handshake. Pulse on ch0, then sync_ready[0]=1 one cycle. Expect sync_valid[0]->0 and ack_toggle[0] 0->1. A second event plus ready gives ack 1->0.
- Overrun. Event ch2 with data 0x11, ready held 0, then event with data 0x22. Expect sync_bus[2]=0x22, overrun[2]=1 until overrun_clr[2]. Assert overrun_clr together with a third unready event: expect overrun stays 1.
- Toggle mode, TOGGLE_MODE=1. bus_enable[3] 0->1, wait 6 cycles, then 1->0. Expect 2 pulses with data 0x3C then 0xC3. Same event and ready cycle: valid stays 1, ack flips, no overrun.
- Reset mid-flight. Assert RST one cycle after the enable rises with bus_enable held 1. Expect no pulse during reset; one pulse 3 edges after RST deasserts.
